// File: rtl/aes_pkg.sv
// Shared AES types and constants for the inverse-round datapath.
package aes_pkg;

  localparam int unsigned AES_NB = 4;

  // Byte-addressed state, indexed [row][col].
  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sb_state_e;

endpackage

// File: rtl/aes_inv_s_table.sv
// Combinational AES inverse S-box: high nibble selects the row, low nibble the column.
module aes_inv_s_table (
  input  logic [3:0] row_num,
  input  logic [3:0] col_num,
  output logic [7:0] aes_inv_table_out
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [7:0] w_idx;

  assign w_idx             = {row_num, col_num};
  assign aes_inv_table_out = INV_SBOX[w_idx];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Column-serial AES InvSubBytes stage with valid/ready on both sides.
// Define INV_SUB_BYTES_PARALLEL_EN to substitute the whole state in one cycle.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [0:3][0:3][DATA_WIDTH-1:0]    in_state,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [0:3][0:3][DATA_WIDTH-1:0]    out_state,
  output logic                               out_valid,
  input  logic                               out_ready
);

  inv_sb_state_e r_state;
  aes_state_t    r_buf;
  aes_state_t    r_out;
  aes_state_t    w_next_out;
  logic          w_busy_last;

`ifndef INV_SUB_BYTES_PARALLEL_EN
  logic [1:0]                r_col_cnt;
  logic [0:AES_NB-1][7:0]    w_sub_col;

  for (genvar gr = 0; gr < AES_NB; gr++) begin : g_row
    aes_inv_s_table u_inv_sbox (
      .row_num          (r_buf[gr][r_col_cnt][7:4]),
      .col_num          (r_buf[gr][r_col_cnt][3:0]),
      .aes_inv_table_out(w_sub_col[gr])
    );
  end

  // Only the current column is replaced; other columns keep their old bytes.
  always_comb begin
    w_next_out               = r_out;
    w_next_out[0][r_col_cnt] = w_sub_col[0];
    w_next_out[1][r_col_cnt] = w_sub_col[1];
    w_next_out[2][r_col_cnt] = w_sub_col[2];
    w_next_out[3][r_col_cnt] = w_sub_col[3];
  end

  assign w_busy_last = (r_col_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_col_cnt <= '0;
    end else if (r_state == BUSY && !w_busy_last) begin
      r_col_cnt <= r_col_cnt + 2'd1;
    end
  end
`else
  aes_state_t w_sub;

  for (genvar gr = 0; gr < AES_NB; gr++) begin : g_row
    for (genvar gc = 0; gc < AES_NB; gc++) begin : g_col
      aes_inv_s_table u_inv_sbox (
        .row_num          (r_buf[gr][gc][7:4]),
        .col_num          (r_buf[gr][gc][3:0]),
        .aes_inv_table_out(w_sub[gr][gc])
      );
    end
  end

  assign w_next_out  = w_sub;
  assign w_busy_last = 1'b1;
`endif

  // in_ready is decoded from state alone, so IDLE gating covers in_valid&&in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_buf   <= in_state;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_out <= w_next_out;
          if (w_busy_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_state = r_out;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed self-checking bench for inv_sub_bytes_seq (serial or parallel build).
module tb_inv_sub_bytes_seq;
  import aes_pkg::*;

`ifdef INV_SUB_BYTES_PARALLEL_EN
  localparam int LAT = 1;
  localparam int II  = 3;
`else
  localparam int LAT = 4;
  localparam int II  = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  aes_state_t in_state;
  logic       in_valid;
  logic       in_ready;
  aes_state_t out_state;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fwd_sbox [0:255];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_state (in_state),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_state(out_state),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (in_ready && out_valid) begin
        n_err++;
        $display("FAIL ready_valid_excl: in_ready=%0b out_valid=%0b, required not both 1", in_ready, out_valid);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic aes_state_t fill(input logic [7:0] b);
    fill = {16{b}};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from GF(2^8) inversion plus the affine map, independent of any table.
  task automatic build_fwd_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      fwd_sbox[x] = s;
    end
  endtask

  task automatic run_block(input aes_state_t s, output aes_state_t res, output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    res = '0;
    in_state = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    res = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++;
    if (out_state !== '0) begin n_err++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_known_bytes();
    aes_state_t s [3];
    aes_state_t e [3];
    aes_state_t res;
    int         lat;
    bit         to;
    s[0] = fill(8'h63); e[0] = fill(8'h00);
    s[1] = fill(8'h00); e[1] = fill(8'h52);
    s[2] = fill(8'h63); e[2] = fill(8'h00);
    s[2][0][0] = 8'h7c; e[2][0][0] = 8'h01;
    s[2][3][3] = 8'h16; e[2][3][3] = 8'hff;
    s[2][1][2] = 8'hed; e[2][1][2] = 8'h53;
    for (int k = 0; k < 3; k++) begin
      run_block(s[k], res, lat, to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL known_timeout[%0d]: handshake did not complete within bound", k); end
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL known_latency[%0d]: got %0d want %0d", k, lat, LAT); end
      n_cmp++;
      if (res !== e[k]) begin n_err++; $display("FAIL known_data[%0d]: got %h want %h", k, res, e[k]); end
    end
  endtask

  task automatic test_reset_in_busy();
    aes_state_t res;
    int         lat;
    int         n;
    bit         to;
    bit         saw_valid;
    in_state = fill(8'h00);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_out_valid: got %0b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_busy_in_ready: got %0b want 1", in_ready); end
    n_cmp++;
    if (out_state !== '0) begin n_err++; $display("FAIL rst_busy_out_state: got %h want 0", out_state); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_no_output: got out_valid=1 want 0 after reset"); end
    run_block(fill(8'h63), res, lat, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL rst_busy_fresh_timeout: handshake did not complete within bound"); end
    n_cmp++;
    if (res !== fill(8'h00)) begin n_err++; $display("FAIL rst_busy_fresh_data: got %h want %h", res, fill(8'h00)); end
  endtask

  task automatic test_round_trip();
    aes_state_t orig;
    aes_state_t s;
    aes_state_t res;
    int         lat;
    bit         to;
    for (int k = 0; k < 1000; k++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          orig[r][c] = 8'($urandom_range(0, 255));
          s[r][c]    = fwd_sbox[orig[r][c]];
        end
      end
      run_block(s, res, lat, to);
      n_cmp++;
      if (to || res !== orig) begin
        n_err++;
        $display("FAIL round_trip[%0d]: got %h want %h (timeout=%0b)", k, res, orig, to);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    in_state = fill(8'hed);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_state = fill(8'h7c);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (n !== LAT) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", n, LAT); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== fill(8'h53)) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%0b ready=%0b data=%h want valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, out_state, fill(8'h53));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_single_handshake: got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_pending_accept: got in_ready=%0b want 0", in_ready); end
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== fill(8'h01)) begin
      n_err++;
      $display("FAIL bp_pending_data: got valid=%0b data=%h want valid=1 data=%h", out_valid, out_state, fill(8'h01));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] fills [5];
    logic [7:0] exps  [5];
    int         acc_cyc [5];
    int         acc_n;
    int         out_n;
    int         cyc;
    bit         acc_now;
    fills[0] = 8'h63; exps[0] = 8'h00;
    fills[1] = 8'h00; exps[1] = 8'h52;
    fills[2] = 8'h7c; exps[2] = 8'h01;
    fills[3] = 8'h16; exps[3] = 8'hff;
    fills[4] = 8'hed; exps[4] = 8'h53;
    acc_n = 0;
    out_n = 0;
    cyc   = 0;
    in_state  = fill(fills[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (out_n < 5 && cyc < 100) begin
      acc_now = 1'b0;
      if (in_ready && acc_n < 5) begin
        acc_cyc[acc_n] = cyc;
        acc_now = 1'b1;
      end
      if (out_valid) begin
        n_cmp++;
        if (out_state !== fill(exps[out_n])) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h want %h", out_n, out_state, fill(exps[out_n]));
        end
        out_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_n++;
        if (acc_n < 5) in_state = fill(fills[acc_n]);
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_n !== 5 || acc_n !== 5) begin
      n_err++;
      $display("FAIL b2b_count: got accepts=%0d outputs=%0d want 5/5", acc_n, out_n);
    end
    for (int k = 1; k < acc_n; k++) begin
      n_cmp++;
      if (acc_cyc[k] - acc_cyc[k-1] !== II) begin
        n_err++;
        $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, acc_cyc[k] - acc_cyc[k-1], II);
      end
    end
  endtask

  initial begin
    build_fwd_sbox();
    test_reset();
    test_known_bytes();
    test_reset_in_busy();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
